// File: rtl/seventy_two_bit_pkg.sv
// Shared types for the 72-bit processor fetch path: instruction and address
// widths, and the entry stored in the fetch FIFOs (instruction plus its PC).
package seventy_two_bit_pkg;

    localparam int IW = 72;
    localparam int AW = 16;

    typedef logic [IW-1:0] instr_t;
    typedef logic [AW-1:0] addr_t;

    typedef struct packed {
        instr_t instr;
        addr_t  addr;
    } fetch_entry_t;

endpackage

// File: rtl/seventy_two_bit_fetch_fifo.sv
// Small synchronous FIFO of fetch entries with push, pop, flush and an
// occupancy count. The head entry is always presented combinationally.
// Used for both the instruction prefetch buffer and the request tag queue.
module seventy_two_bit_fetch_fifo
    import seventy_two_bit_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  fetch_entry_t  push_data,
    input  logic          pop,
    input  logic          flush,
    output fetch_entry_t  head,
    output logic [CW-1:0] count,
    output logic          empty,
    output logic          full
);

    fetch_entry_t  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    // Pointer and occupancy bookkeeping; flush empties the queue in one cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Entry storage, cleared on reset so the head reads as zero when idle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (do_push && !flush) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/seventy_two_bit_fetch_unit.sv
// Instruction fetch front end for the 72-bit processor. Keeps the fetch PC,
// issues in-order word requests under a credit limit so every response has a
// buffer slot, tags responses with their PC, and hands instructions to decode.
// Redirects from execute flush buffered work and drop stale responses.
// Optional macro SEVENTY_TWO_FETCH_PERF_EN adds saturating performance
// counters perf_fetched and perf_stall.
module seventy_two_bit_fetch_unit
    import seventy_two_bit_pkg::*;
#(
    parameter int            IW       = 72,
    parameter int            AW       = 16,
    parameter int            DEPTH    = 4,
    parameter logic [AW-1:0] RESET_PC = '0
) (
    input  logic          clk,
    input  logic          rst,
    output logic          imem_req_valid,
    input  logic          imem_req_ready,
    output logic [AW-1:0] imem_req_addr,
    input  logic          imem_resp_valid,
    input  logic [IW-1:0] imem_resp_data,
    input  logic          redirect_valid,
    input  logic [AW-1:0] redirect_pc,
    output logic          dec_valid,
    input  logic          dec_ready,
    output logic [IW-1:0] dec_instr,
    output logic [AW-1:0] dec_pc
`ifdef SEVENTY_TWO_FETCH_PERF_EN
    ,
    output logic [31:0]   perf_fetched,
    output logic [31:0]   perf_stall
`endif
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [AW-1:0] fetch_pc;
    logic [CW-1:0] inflight;
    logic [CW-1:0] inflight_next;
    logic [CW-1:0] drop;
    logic [CW-1:0] count;
    logic [CW-1:0] tag_count;
    logic [CW:0]   credit_used;
    logic          armed;
    logic          req_fire;
    logic          resp_keep;
    logic          dec_fire;
    logic          data_empty;
    logic          data_full;
    logic          tag_empty;
    logic          tag_full;
    fetch_entry_t  tag_in;
    fetch_entry_t  tag_head;
    fetch_entry_t  data_in;
    fetch_entry_t  data_head;
    logic          unused_status;

    assign credit_used    = {1'b0, count} + {1'b0, inflight};
    assign imem_req_valid = armed && (credit_used < (CW+1)'(DEPTH)) && !redirect_valid;
    assign imem_req_addr  = fetch_pc;
    assign req_fire       = imem_req_valid && imem_req_ready;
    assign resp_keep      = imem_resp_valid && (drop == '0) && !redirect_valid;
    assign dec_valid      = !data_empty;
    assign dec_fire       = dec_valid && dec_ready && !redirect_valid;
    assign dec_instr      = data_head.instr;
    assign dec_pc         = data_head.addr;
    assign inflight_next  = inflight + CW'(req_fire) - CW'(imem_resp_valid);

    assign tag_in.instr   = '0;
    assign tag_in.addr    = fetch_pc;
    assign data_in.instr  = imem_resp_data;
    assign data_in.addr   = tag_head.addr;

    assign unused_status  = ^{tag_head.instr, tag_count, tag_empty, tag_full, data_full};

    // Requests start one cycle after reset is released
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            armed <= 1'b0;
        end else begin
            armed <= 1'b1;
        end
    end

    // Fetch PC, outstanding-request count and stale-response drop count
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc <= RESET_PC;
            inflight <= '0;
            drop     <= '0;
        end else begin
            inflight <= inflight_next;
            if (redirect_valid) begin
                fetch_pc <= redirect_pc;
                drop     <= inflight_next;
            end else begin
                if (req_fire) begin
                    fetch_pc <= fetch_pc + 1'b1;
                end
                if (imem_resp_valid && (drop != '0)) begin
                    drop <= drop - 1'b1;
                end
            end
        end
    end

    seventy_two_bit_fetch_fifo #(.DEPTH(DEPTH)) u_tag_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (req_fire),
        .push_data (tag_in),
        .pop       (resp_keep),
        .flush     (redirect_valid),
        .head      (tag_head),
        .count     (tag_count),
        .empty     (tag_empty),
        .full      (tag_full)
    );

    seventy_two_bit_fetch_fifo #(.DEPTH(DEPTH)) u_data_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (resp_keep),
        .push_data (data_in),
        .pop       (dec_fire),
        .flush     (redirect_valid),
        .head      (data_head),
        .count     (count),
        .empty     (data_empty),
        .full      (data_full)
    );

`ifdef SEVENTY_TWO_FETCH_PERF_EN
    // Saturating counts of delivered instructions and starved decode cycles
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_fetched <= '0;
            perf_stall   <= '0;
        end else begin
            if (dec_fire && (perf_fetched != '1)) begin
                perf_fetched <= perf_fetched + 32'd1;
            end
            if (dec_ready && !dec_valid && !redirect_valid && (perf_stall != '1)) begin
                perf_stall <= perf_stall + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_seventy_two_bit_fetch_unit.sv
// Self-checking bench for seventy_two_bit_fetch_unit. A behavioural memory
// returns in-order responses after a chosen latency; the reference model
// says decode must see consecutive word addresses starting at the reset PC
// or the latest redirect target, each carrying that address's memory word.
module tb_seventy_two_bit_fetch_unit;

    localparam int DEPTH = 4;

    typedef struct {
        logic [15:0] addr;
        int          due;
    } mreq_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [15:0] imem_req_addr;
    logic        imem_resp_valid = 1'b0;
    logic [71:0] imem_resp_data = '0;
    logic        redirect_valid = 1'b0;
    logic [15:0] redirect_pc = '0;
    logic        dec_valid;
    logic        dec_ready = 1'b0;
    logic [71:0] dec_instr;
    logic [15:0] dec_pc;
`ifdef SEVENTY_TWO_FETCH_PERF_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_stall;
`endif

    mreq_t       mq[$];
    logic [15:0] seen[$];
    int          cyc = 0;
    int          last_due = 0;
    int          lat_lo = 1;
    int          lat_hi = 1;
    int          total = 0;
    int          bad = 0;
    int          fires = 0;
    logic [15:0] exp_pc = '0;
    logic [15:0] exp_req = '0;
    logic [31:0] exp_fetched = '0;
    logic [31:0] exp_stall = '0;

    seventy_two_bit_fetch_unit #(
        .IW       (72),
        .AW       (16),
        .DEPTH    (DEPTH),
        .RESET_PC (16'h0000)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .dec_valid       (dec_valid),
        .dec_ready       (dec_ready),
        .dec_instr       (dec_instr),
        .dec_pc          (dec_pc)
`ifdef SEVENTY_TWO_FETCH_PERF_EN
        ,
        .perf_fetched    (perf_fetched),
        .perf_stall      (perf_stall)
`endif
    );

    always #5 clk = ~clk;

    // Contents of instruction memory at a word address
    function automatic logic [71:0] mem_word(input logic [15:0] a);
        logic [15:0] m;
        logic [7:0]  lo;
        m  = a * 16'd3 + 16'h1234;
        lo = a[7:0] ^ 8'hc3;
        return {a, ~a, a ^ 16'h5a5a, m, lo};
    endfunction

    // Clear memory pipeline and reference model, pulse reset for two cycles
    task automatic do_reset();
        rst = 1'b0;
        dec_ready = 1'b0;
        imem_req_ready = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        imem_resp_valid = 1'b0;
        imem_resp_data = '0;
        mq.delete();
        seen.delete();
        last_due = cyc;
        exp_pc = '0;
        exp_req = '0;
        exp_fetched = '0;
        exp_stall = '0;
        fires = 0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    // One clock cycle: drive inputs, play memory, score against the model
    task automatic run_cycle(input logic dr, input logic rr, input logic rv, input logic [15:0] rpc);
        int due;
        dec_ready = dr;
        imem_req_ready = rr;
        redirect_valid = rv;
        redirect_pc = rpc;
        if (mq.size() > 0 && mq[0].due == cyc) begin
            imem_resp_valid = 1'b1;
            imem_resp_data = mem_word(mq[0].addr);
            void'(mq.pop_front());
        end else begin
            imem_resp_valid = 1'b0;
            imem_resp_data = '0;
        end
        #1;
        if (rv) begin
            total++;
            if (imem_req_valid !== 1'b0) begin
                bad++;
                $display("[TB] FAIL req_in_redirect: req_valid=%b want 0 cyc=%0d", imem_req_valid, cyc);
            end
        end
        if (imem_req_valid === 1'b1 && rr) begin
            total++;
            if (imem_req_addr !== exp_req) begin
                bad++;
                $display("[TB] FAIL req_addr: got %h want %h cyc=%0d", imem_req_addr, exp_req, cyc);
            end
            due = cyc + int'($urandom_range(lat_hi, lat_lo));
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            mq.push_back('{addr: exp_req, due: due});
            exp_req = exp_req + 16'd1;
            fires++;
        end
        if (dec_valid === 1'b1 && dr && !rv) begin
            total++;
            if (dec_pc !== exp_pc || dec_instr !== mem_word(exp_pc)) begin
                bad++;
                $display("[TB] FAIL dec_out: pc=%h instr=%h want pc=%h instr=%h", dec_pc, dec_instr, exp_pc, mem_word(exp_pc));
            end
            seen.push_back(exp_pc);
            exp_pc = exp_pc + 16'd1;
            exp_fetched = exp_fetched + 32'd1;
        end
        if (dr && dec_valid === 1'b0 && !rv) begin
            exp_stall = exp_stall + 32'd1;
        end
        if (rv) begin
            exp_pc = rpc;
            exp_req = rpc;
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    // Outputs while reset is held
    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        total++;
        if (imem_req_valid !== 1'b0) begin bad++; $display("[TB] FAIL rst_req_valid: got %b want 0", imem_req_valid); end
        total++;
        if (dec_valid !== 1'b0) begin bad++; $display("[TB] FAIL rst_dec_valid: got %b want 0", dec_valid); end
        total++;
        if (imem_req_addr !== 16'h0000) begin bad++; $display("[TB] FAIL rst_req_addr: got %h want 0000", imem_req_addr); end
        total++;
        if (dec_instr !== 72'h0) begin bad++; $display("[TB] FAIL rst_dec_instr: got %h want 0", dec_instr); end
        total++;
        if (dec_pc !== 16'h0000) begin bad++; $display("[TB] FAIL rst_dec_pc: got %h want 0000", dec_pc); end
`ifdef SEVENTY_TWO_FETCH_PERF_EN
        total++;
        if (perf_fetched !== 32'd0 || perf_stall !== 32'd0) begin bad++; $display("[TB] FAIL rst_perf: got %0d/%0d want 0/0", perf_fetched, perf_stall); end
`endif
    endtask

    // Streaming from reset with single-cycle memory and decode always ready
    task automatic test_startup();
        do_reset();
        lat_lo = 1; lat_hi = 1;
        repeat (20) run_cycle(1'b1, 1'b1, 1'b0, 16'h0);
        total++;
        if (seen.size() < 16) begin bad++; $display("[TB] FAIL startup_rate: got %0d instrs want >=16", seen.size()); end
        total++;
        if (seen.size() == 0 || seen[0] !== 16'h0000) begin bad++; $display("[TB] FAIL startup_first_pc: got %0d entries want first pc 0000", seen.size()); end
    endtask

    // Decode stalled: credit limit caps requests at DEPTH, nothing is lost
    task automatic test_backpressure();
        do_reset();
        lat_lo = 1; lat_hi = 1;
        repeat (10) run_cycle(1'b0, 1'b1, 1'b0, 16'h0);
        total++;
        if (fires != DEPTH) begin bad++; $display("[TB] FAIL bp_requests: got %0d want %0d", fires, DEPTH); end
        total++;
        if (imem_req_valid !== 1'b0) begin bad++; $display("[TB] FAIL bp_req_valid: got %b want 0", imem_req_valid); end
        repeat (20) run_cycle(1'b1, 1'b1, 1'b0, 16'h0);
        total++;
        if (seen.size() < 12) begin bad++; $display("[TB] FAIL bp_resume: got %0d instrs want >=12", seen.size()); end
    endtask

    // Redirect with two requests outstanding at 3-cycle latency
    task automatic test_redirect();
        int guard;
        do_reset();
        lat_lo = 3; lat_hi = 3;
        guard = 0;
        while (mq.size() != 2 && guard < 50) begin
            run_cycle(1'b1, 1'b1, 1'b0, 16'h0);
            guard++;
        end
        total++;
        if (guard >= 50) begin bad++; $display("[TB] FAIL redir_setup: outstanding=%0d want 2", mq.size()); end
        seen.delete();
        run_cycle(1'b1, 1'b1, 1'b1, 16'h0100);
        redirect_valid = 1'b0;
        #1;
        total++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 16'h0100) begin
            bad++;
            $display("[TB] FAIL redir_next_req: valid=%b addr=%h want 1/0100", imem_req_valid, imem_req_addr);
        end
        repeat (20) run_cycle(1'b1, 1'b1, 1'b0, 16'h0);
        total++;
        if (seen.size() == 0 || seen[0] !== 16'h0100) begin bad++; $display("[TB] FAIL redir_first_pc: got %0d entries want first pc 0100", seen.size()); end
    endtask

    // Redirect in the same cycle a response returns
    task automatic test_collide();
        int guard;
        do_reset();
        lat_lo = 2; lat_hi = 2;
        guard = 0;
        while (!(cyc >= 0 && fires >= 3 && mq.size() > 0 && mq[0].due == cyc) && guard < 50) begin
            run_cycle(1'b1, 1'b1, 1'b0, 16'h0);
            guard++;
        end
        total++;
        if (guard >= 50) begin bad++; $display("[TB] FAIL collide_setup: no response slot found"); end
        seen.delete();
        run_cycle(1'b1, 1'b1, 1'b1, 16'h0100);
        repeat (20) run_cycle(1'b1, 1'b1, 1'b0, 16'h0);
        total++;
        if (seen.size() == 0 || seen[0] !== 16'h0100) begin bad++; $display("[TB] FAIL collide_first_pc: got %0d entries want first pc 0100", seen.size()); end
    endtask

    // Address wrap at the top of the 16-bit space
    task automatic test_wrap();
        do_reset();
        lat_lo = 1; lat_hi = 1;
        repeat (5) run_cycle(1'b1, 1'b1, 1'b0, 16'h0);
        seen.delete();
        run_cycle(1'b1, 1'b1, 1'b1, 16'hfffe);
        repeat (15) run_cycle(1'b1, 1'b1, 1'b0, 16'h0);
        total++;
        if (seen.size() < 3 || seen[0] !== 16'hfffe || seen[1] !== 16'hffff || seen[2] !== 16'h0000) begin
            bad++;
            $display("[TB] FAIL wrap_seq: got %0d entries want fffe,ffff,0000", seen.size());
        end
    endtask

    // Random readiness, latency and redirects against the reference model
    task automatic test_random();
        logic        dr;
        logic        rr;
        logic        rv;
        logic [15:0] rpc;
        do_reset();
        lat_lo = 1; lat_hi = 4;
        for (int i = 0; i < 600; i++) begin
            dr  = ($urandom_range(3, 0) != 0);
            rr  = ($urandom_range(3, 0) != 0);
            rv  = ($urandom_range(19, 0) == 0);
            rpc = 16'($urandom);
            run_cycle(dr, rr, rv, rpc);
        end
        total++;
        if (seen.size() < 100) begin bad++; $display("[TB] FAIL rand_progress: got %0d instrs want >=100", seen.size()); end
`ifdef SEVENTY_TWO_FETCH_PERF_EN
        total++;
        if (perf_fetched !== exp_fetched) begin bad++; $display("[TB] FAIL perf_fetched: got %0d want %0d", perf_fetched, exp_fetched); end
        total++;
        if (perf_stall !== exp_stall) begin bad++; $display("[TB] FAIL perf_stall: got %0d want %0d", perf_stall, exp_stall); end
`endif
    endtask

    // Reset asserted with a full buffer, then restart from the reset PC
    task automatic test_reset_mid();
        do_reset();
        lat_lo = 1; lat_hi = 1;
        repeat (5) run_cycle(1'b1, 1'b1, 1'b0, 16'h0);
        repeat (8) run_cycle(1'b0, 1'b1, 1'b0, 16'h0);
        total++;
        if (dec_valid !== 1'b1) begin bad++; $display("[TB] FAIL mid_prefill: dec_valid=%b want 1", dec_valid); end
        rst = 1'b0;
        imem_resp_valid = 1'b0;
        imem_resp_data = '0;
        mq.delete();
        #1;
        total++;
        if (dec_valid !== 1'b0) begin bad++; $display("[TB] FAIL mid_dec_valid: got %b want 0", dec_valid); end
        total++;
        if (imem_req_valid !== 1'b0) begin bad++; $display("[TB] FAIL mid_req_valid: got %b want 0", imem_req_valid); end
`ifdef SEVENTY_TWO_FETCH_PERF_EN
        total++;
        if (perf_fetched !== 32'd0) begin bad++; $display("[TB] FAIL mid_perf_fetched: got %0d want 0", perf_fetched); end
`endif
        do_reset();
        repeat (15) run_cycle(1'b1, 1'b1, 1'b0, 16'h0);
        total++;
        if (seen.size() == 0 || seen[0] !== 16'h0000) begin bad++; $display("[TB] FAIL mid_restart_pc: got %0d entries want first pc 0000", seen.size()); end
    endtask

    // Test sequence
    initial begin
        @(negedge clk);
        test_reset();
        test_startup();
        test_backpressure();
        test_redirect();
        test_collide();
        test_wrap();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Watchdog against a hung run
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: run did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
